// File: rtl/count_key_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : count_key_ctrl
//  Purpose  : Single-key controller for the display up/down counter.
//             Classifies each debounced press as short, long or (optionally)
//             very long and drives the counter's next/dir/clr controls,
//             including a free-running auto-count mode.
//             Optional feature macro: KEY_CTRL_CLR_EN (very-long-press clear).
//  Revision : 1.0 - initial release
// ============================================================================
module count_key_ctrl #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int AUTO_PERIOD = 10_000_000,
  parameter int CLR_CYCLES  = 200_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic next_o,
  output logic dir_o,
  output logic run_o,
  output logic clr_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2,
    ST_CLRW = 2'd3
  } state_t;

  localparam logic [31:0] c_LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] c_AUTO_LAST = 32'(AUTO_PERIOD - 1);
  localparam logic [31:0] c_HOLD_MAX  = 32'hFFFF_FFFF;
`ifdef KEY_CTRL_CLR_EN
  localparam logic [31:0] c_CLR_LAST  = 32'(CLR_CYCLES - 1);
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_key_q;
  logic [31:0] r_hcnt;
  logic [31:0] r_pcnt;
  logic        r_run_q;
  logic        r_next;
  logic        r_dir;
  logic        r_run;
  logic        r_clr;

  logic        w_press;
  logic        w_release;
  logic [31:0] w_hold;
  logic        w_tick;
  logic        w_short_step;
  logic        w_next_nxt;
  logic        w_dir_nxt;
  logic        w_run_nxt;
  logic        w_clr_nxt;

  assign w_press   = key_i & ~r_key_q;
  assign w_release = ~key_i & r_key_q;

  // Hold count as seen in the current cycle: 0 in the press-edge cycle,
  // otherwise the registered value. The register therefore holds the count
  // that applies to the following cycle.
  assign w_hold = w_press ? 32'd0 : r_hcnt;

  // An auto tick only fires once pcnt has been running for a full period
  // after the run_o transition cycle (pcnt is reloaded during that cycle).
  assign w_tick = r_run & (r_run == r_run_q) & (r_pcnt == c_AUTO_LAST);

  // Key delay register; resets high so a key held through reset is not a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_key_q <= 1'b1;
    end else begin
      r_key_q <= key_i;
    end
  end

  // Saturating hold counter, advancing every cycle the key is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hcnt <= 32'd0;
    end else if (key_i && (w_hold != c_HOLD_MAX)) begin
      r_hcnt <= w_hold + 32'd1;
    end else if (key_i) begin
      r_hcnt <= c_HOLD_MAX;
    end
  end

  // Auto-count period counter: held at 0 while idle, reloaded on every run_o change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pcnt  <= 32'd0;
      r_run_q <= 1'b0;
    end else begin
      r_run_q <= r_run;
      if (!r_run || (r_run != r_run_q)) begin
        r_pcnt <= 32'd0;
      end else if (r_pcnt == c_AUTO_LAST) begin
        r_pcnt <= 32'd0;
      end else begin
        r_pcnt <= r_pcnt + 32'd1;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_next  <= 1'b0;
      r_dir   <= 1'b0;
      r_run   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_next  <= w_next_nxt;
      r_dir   <= w_dir_nxt;
      r_run   <= w_run_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

  // Press classification: next state and next output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_short_step = 1'b0;
    w_dir_nxt    = r_dir;
    w_run_nxt    = r_run;
    w_clr_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          if (r_run) begin
            w_dir_nxt = ~r_dir;
          end else begin
            w_short_step = 1'b1;
          end
        end else if (key_i && (w_hold == c_LONG_LAST)) begin
          w_run_nxt   = ~r_run;
          w_state_nxt = ST_LONG;
        end
      end
      ST_LONG: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
`ifdef KEY_CTRL_CLR_EN
        end else if (key_i && (w_hold == c_CLR_LAST)) begin
          w_clr_nxt   = 1'b1;
          w_run_nxt   = 1'b0;
          w_dir_nxt   = 1'b0;
          w_state_nxt = ST_CLRW;
`endif
        end
      end
`ifdef KEY_CTRL_CLR_EN
      ST_CLRW: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A clear pulse wins over any step that would land in the same cycle.
  assign w_next_nxt = (w_short_step | w_tick) & ~w_clr_nxt;

`ifndef KEY_CTRL_CLR_EN
  // The clear threshold has no function without the clear feature.
  logic w_unused_clr;
  assign w_unused_clr = ^(32'(CLR_CYCLES));
`endif

  assign next_o = r_next;
  assign dir_o  = r_dir;
  assign run_o  = r_run;
  assign clr_o  = r_clr;

endmodule
`default_nettype wire

// File: tb/tb_count_key_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_count_key_ctrl
//  Purpose  : Self-checking bench for count_key_ctrl. A press-length based
//             reference model predicts all four outputs every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_count_key_ctrl;

  localparam int LONG = 8;
  localparam int AUTO = 5;
  localparam int CLR  = 20;
`ifdef KEY_CTRL_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic key_i;
  logic next_o;
  logic dir_o;
  logic run_o;
  logic clr_o;

  always #5 clk_i = ~clk_i;

  count_key_ctrl #(
    .LONG_CYCLES (LONG),
    .AUTO_PERIOD (AUTO),
    .CLR_CYCLES  (CLR)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .key_i  (key_i),
    .next_o (next_o),
    .dir_o  (dir_o),
    .run_o  (run_o),
    .clr_o  (clr_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: press tracking in terms of cycles held.
  bit   m_prev;
  bit   m_active;
  bit   m_run;
  bit   m_dir;
  int   m_hold;
  int   m_stage;   // 0 = short so far, 1 = long reached, 2 = cleared
  int   m_rise;    // cycle in which run_o became visible
  logic e_next = 1'b0;
  logic e_dir  = 1'b0;
  logic e_run  = 1'b0;
  logic e_clr  = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Predict the outputs of the next cycle from the key level of this cycle.
  task automatic model_update(input bit k, input bit r);
    bit press;
    bit rel;
    bit nxt;
    bit clr;
    int d;
    if (r) begin
      m_prev = 1'b1; m_active = 1'b0; m_run = 1'b0; m_dir = 1'b0;
      m_hold = 0;    m_stage = 0;
      e_next = 1'b0; e_dir = 1'b0; e_run = 1'b0; e_clr = 1'b0;
      return;
    end
    press = k && !m_prev;
    rel   = !k && m_prev;
    nxt   = 1'b0;
    clr   = 1'b0;
    if (m_run) begin
      d = cyc - m_rise;
      if (d >= AUTO && ((d - AUTO) % AUTO) == 0) nxt = 1'b1;
    end
    if (press) begin
      m_active = 1'b1; m_hold = 1; m_stage = 0;
    end else if (m_active && k) begin
      m_hold++;
    end
    if (m_active && k) begin
      if (m_stage == 0 && m_hold == LONG) begin
        m_run = !m_run;
        if (m_run) m_rise = cyc + 1;
        m_stage = 1;
      end else if (CLR_EN && m_stage == 1 && m_hold == CLR) begin
        clr = 1'b1; m_run = 1'b0; m_dir = 1'b0; m_stage = 2;
      end
    end
    if (m_active && rel) begin
      if (m_stage == 0) begin
        if (m_run) m_dir = !m_dir;
        else       nxt = 1'b1;
      end
      m_active = 1'b0;
    end
    if (clr) nxt = 1'b0;
    m_prev = k;
    e_next = nxt; e_dir = m_dir; e_run = m_run; e_clr = clr;
  endtask

  // Check the current cycle, then drive key/reset for it and advance.
  task automatic step(input bit k, input bit r);
    chk("next_o", next_o, e_next);
    chk("dir_o",  dir_o,  e_dir);
    chk("run_o",  run_o,  e_run);
    chk("clr_o",  clr_o,  e_clr);
    key_i = k;
    rst_i = r;
    model_update(k, r);
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    key_i = 1'b0;
    model_update(1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    cyc = 1;

    // Reset state and a short press while stopped.
    step(0, 1);
    repeat (2) step(0, 0);
    repeat (3) step(1, 0);
    repeat (4) step(0, 0);

    // Long press enters auto-count, then free-running ticks.
    repeat (10) step(1, 0);
    repeat (16) step(0, 0);

    // Short press while running, released in a tick cycle.
    n = 0;
    while (!e_next && n < 20) begin
      step(0, 0);
      n++;
    end
    chk("tick_found", e_next, 1'b1);
    step(0, 0);
    repeat (3) step(1, 0);
    step(0, 0);
    chk("align_dir",  dir_o,  1'b1);
    chk("align_next", next_o, 1'b1);
    repeat (8) step(0, 0);

    // Very long press from the running state.
    repeat (25) step(1, 0);
    repeat (6) step(0, 0);

    // Key held through reset, then released: no outputs.
    repeat (2) step(1, 1);
    repeat (4) step(1, 0);
    repeat (5) step(0, 0);

    // Reset during a held press: the release is ignored.
    repeat (3) step(1, 0);
    step(1, 1);
    repeat (2) step(1, 0);
    repeat (5) step(0, 0);

    // Randomized presses with occasional reset pulses.
    for (int i = 0; i < 60; i++) begin
      int h;
      int g;
      int rr;
      h  = $urandom_range(1, 26);
      g  = $urandom_range(1, 12);
      rr = $urandom_range(0, 9);
      for (int j = 0; j < h; j++) step(1, (rr == 0) && (j == h / 2));
      for (int j = 0; j < g; j++) step(0, 0);
    end
    repeat (4) step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
